imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader and instruction memory for the Y86 SEQ core. Accepts a
//  byte stream over a valid/ready handshake: 16-bit length, payload, then XOR checksum.
//  Stores the payload at BOOT_OFFSET and up, and serves 10-byte fetch windows to fetch.
//  Holds the core (cpu_hold) until a load completes cleanly.
// PARAMETERS
//  MEM_DEPTH   256    instruction memory size in bytes (power of 2)
//  ADDR_W      8      log2(MEM_DEPTH)
//  BOOT_OFFSET 1      first payload address; mem[0] holds the boot nop
//  BOOT_BYTE   8'h10  value placed at mem[0] on reset (nop)
// PORTS
//  clk          in   1   system clock, all state updates on posedge
//  rst          in   1   asynchronous active-high reset
//  in_valid     in   1   stream byte valid
//  in_data      in   8   stream byte
//  in_ready     out  1   loader can accept a byte; a transfer is in_valid & in_ready at posedge
//  reload       in   1   1-cycle pulse; restarts the load from DONE or ERR
//  pc           in   64  fetch address
//  instr        out  80  fetch window; instr[79:72]=mem[pc] ... instr[7:0]=mem[pc+9]
//  imem_error   out  1   pc >= MEM_DEPTH
//  cpu_hold     out  1   core must not advance PC
//  load_done    out  1   load finished, checksum matched
//  load_err     out  1   load rejected (length overflow or checksum mismatch)
//  bytes_loaded out  16  payload bytes written in the current or last load
// BEHAVIOUR
//  Reset (async): state=LEN_LO; mem[0]=BOOT_BYTE, all other bytes 8'h00; len, count, csum=0;
//   in_ready=0 while rst is high; cpu_hold=1; load_done=0; load_err=0; bytes_loaded=0.
//  FSM states: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. in_ready=1 only in LEN_LO/LEN_HI/DATA/CSUM.
//  LEN_LO:  on transfer, len[7:0]=in_data; go to LEN_HI.
//  LEN_HI:  on transfer, len[15:8]=in_data; check the complete 16-bit len:
//   len > MEM_DEPTH-BOOT_OFFSET -> ERR; len==0 -> CSUM; else -> DATA. count=0, csum=0.
//  DATA:    on transfer, mem[BOOT_OFFSET+count]=in_data; csum^=in_data; count++;
//   the transfer where count==len-1 -> CSUM. bytes_loaded tracks count (registered).
//  CSUM:    on transfer, in_data==csum -> DONE; else -> ERR.
//  DONE: cpu_hold=0, load_done=1. ERR: cpu_hold=1, load_err=1. Both are sticky until reload/rst.
//  reload in DONE or ERR -> LEN_LO next cycle; clears load_done, load_err, bytes_loaded;
//   sets cpu_hold=1; memory is NOT cleared. reload in any other state is ignored.
//  No transfer (in_valid=0) -> no state, counter or memory change; gaps of any length are legal.
//  Flag outputs (cpu_hold, load_done, load_err) are registered and change the cycle after the
//   causing transfer. in_ready is combinational from state and rst.
//  Fetch port is combinational from storage: a byte written at edge N is visible after edge N.
//   Any window byte with address >= MEM_DEPTH reads 8'h00. imem_error=(pc>=MEM_DEPTH);
//   when it is set, instr=0. The fetch port is valid in every state, including during load.
//  Address arithmetic uses the full 64-bit pc; no wrap-around past MEM_DEPTH-1.
//  rst asserted mid-load returns to the reset state immediately and clears memory.
// TESTING
//  1 reset, release -> in_ready=1, cpu_hold=1, pc=0 gives instr[79:72]=8'h10, rest 0, load_done=0
//  2 stream 02 00 30 F2 C2 -> DONE one cycle after the C2 transfer; pc=1 gives
//     instr=80'h30F2_0000_0000_0000_0000; bytes_loaded=2; cpu_hold=0
//  3 same stream with in_valid low for 3 cycles between bytes -> identical end state; no extra writes
//  4 stream 01 00 AA 55 (bad csum) -> load_err=1, in_ready=0, cpu_hold=1; reload; then
//     01 00 AA AA -> load_done=1
//  5 stream 00 01 (len=256 > 255) -> ERR after the 2nd byte; mem[1..] unchanged;
//     00 00 00 (len=0) -> DONE
//  6 pc=250 -> mem[250..255] then 4 bytes of 00, imem_error=0; pc=256 -> imem_error=1, instr=0;
//     rst mid-DATA -> mem cleared, state LEN_LO

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// A byte moves on any posedge where in_valid and in_ready are both high.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader and instruction memory for the Y86 SEQ core.
// Takes length, payload and XOR checksum, then releases the core.
module imem_loader #(
    parameter int         MEM_DEPTH   = 256,
    parameter int         ADDR_W      = 8,
    parameter int         BOOT_OFFSET = 1,
    parameter logic [7:0] BOOT_BYTE   = 8'h10
) (
    input  logic                clk,
    input  logic                rst,
    imem_loader_if.slave        ld,
    input  logic                reload,
    input  logic [63:0]         pc,
    output logic [79:0]         instr,
    output logic                imem_error,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_err,
    output logic [15:0]         bytes_loaded
);

    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR
    } state_t;

    state_t      state, state_n;
    logic [7:0]  mem [MEM_DEPTH];
    logic [15:0] len;
    logic [15:0] count;
    logic [15:0] cnt_inc;
    logic [15:0] len_full;
    logic [7:0]  csum;
    logic        xfer;
    logic        len_over;
    logic        restart;
    logic [ADDR_W-1:0] waddr;
    logic [63:0] fa;

    assign ld.in_ready = !rst &&
        (state == LEN_LO || state == LEN_HI ||
         state == DATA   || state == CSUM);

    assign xfer     = ld.in_valid & ld.in_ready;
    assign cnt_inc  = count + 16'd1;
    assign len_full = {ld.in_data, len[7:0]};
    assign len_over = 32'(len_full) > (MEM_DEPTH - BOOT_OFFSET);
    assign restart  = reload && (state == DONE || state == ERR);
    assign waddr    = ADDR_W'(BOOT_OFFSET) + count[ADDR_W-1:0];

    assign bytes_loaded = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LEN_LO;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            LEN_LO: if (xfer) state_n = LEN_HI;
            LEN_HI: begin
                if (xfer) begin
                    if (len_over)            state_n = ERR;
                    else if (len_full == '0) state_n = CSUM;
                    else                     state_n = DATA;
                end
            end
            DATA:   if (xfer && cnt_inc == len) state_n = CSUM;
            CSUM: begin
                if (xfer) state_n = (ld.in_data == csum) ? DONE : ERR;
            end
            DONE, ERR: if (reload) state_n = LEN_LO;
            default: state_n = LEN_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                mem[i] <= (i == 0) ? BOOT_BYTE : 8'h00;
            len       <= '0;
            count     <= '0;
            csum      <= '0;
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            if (state == LEN_LO && xfer)
                len[7:0] <= ld.in_data;
            if (state == LEN_HI && xfer) begin
                len[15:8] <= ld.in_data;
                count     <= '0;
                csum      <= '0;
            end
            if (state == DATA && xfer) begin
                mem[waddr] <= ld.in_data;
                csum       <= csum ^ ld.in_data;
                count      <= cnt_inc;
            end
            if (restart)
                count <= '0;
            cpu_hold  <= (state_n != DONE);
            load_done <= (state_n == DONE);
            load_err  <= (state_n == ERR);
        end
    end

    // Window bytes past the end of memory read as zero; no wrap.
    always_comb begin
        instr      = '0;
        fa         = '0;
        imem_error = (pc >= 64'(MEM_DEPTH));
        for (int i = 0; i < 10; i++) begin
            fa = pc + 64'(i);
            if (!imem_error && fa < 64'(MEM_DEPTH))
                instr[79-8*i -: 8] = mem[fa[ADDR_W-1:0]];
        end
    end

endmodule
